uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver: 8 data bits LSB first, 1 start bit, 1 stop bit, no parity.
//  Sits between the FPGA RX pin and the command decoder, mirroring uart_tx on the same link.
//  Resynchronises the asynchronous serial line, rejects start-bit glitches and samples each bit at its centre.
//  Delivers each byte with a one-cycle valid pulse; flags framing errors.
// PARAMETERS
//  CLOKS_POR_BIT  5209  clock cycles per serial bit (50 MHz / 9600 baud); legal range >= 4
// PORTS
//  clock                input   1  system clock; all logic on posedge
//  reset                input   1  synchronous, active-high reset
//  bitSerialRecebido    input   1  asynchronous serial line; idles high
//  byteRecebido         output  8  last correctly framed byte; held until next good frame
//  dadoValido           output  1  one-cycle pulse: byteRecebido updated this cycle
//  erroDeQuadro         output  1  one-cycle pulse: stop bit sampled low; byte discarded
//  recepcaoEmAndamento  output  1  high from confirmed start bit until the stop-bit sample
// BEHAVIOUR
//  - Reset (synchronous, active-high): FSM = ESPERA, counter = 0, bit index = 0.
//    Sync flops and previous-sample register = 1.
//    byteRecebido = 0x00; dadoValido, erroDeQuadro and recepcaoEmAndamento = 0.
//    Reset mid-frame aborts the frame silently: no pulse on either output.
//  - Input path: 2-FF synchroniser, then one previous-sample register.
//    linhaSync is the second FF; all decisions use linhaSync only.
//  - Counter width: $clog2(CLOKS_POR_BIT). It must never wrap inside a state.
//  - ESPERA: arms only on a falling edge (previous = 1, linhaSync = 0).
//    A line held low (break, or reset released mid-frame) never arms.
//    On arm: counter = 0, go to VERIFICA_INICIO.
//  - VERIFICA_INICIO: count to METADE = (CLOKS_POR_BIT-1)/2.
//    At counter == METADE:
//      linhaSync = 0 -> counter = 0, recepcaoEmAndamento = 1, go to RECEBE_BITS.
//      linhaSync = 1 -> glitch; go to ESPERA, outputs unchanged.
//  - RECEBE_BITS: at counter == CLOKS_POR_BIT-1, shift register[index] <= linhaSync, counter = 0.
//    index < 7 -> index+1; index == 7 -> index = 0, go to RECEBE_FINAL.
//    Each sample therefore lands at bit centre, within +/-1 clock.
//  - RECEBE_FINAL: at counter == CLOKS_POR_BIT-1, sample the stop bit and drop recepcaoEmAndamento.
//      Stop = 1 -> byteRecebido <= shift register, dadoValido = 1 for exactly one cycle.
//      Stop = 0 -> erroDeQuadro = 1 for one cycle; byteRecebido unchanged.
//    Then go to LIMPEZA.
//  - LIMPEZA: one cycle; clear pulses; go to ESPERA.
//    Re-arming still requires a fresh falling edge, so back-to-back frames work:
//    the next start edge arrives about CLOKS_POR_BIT/2 cycles after the stop sample.
//  - dadoValido and erroDeQuadro are never high in the same cycle.
//  - Latency: stop-bit sample at about 2 + METADE + 9*CLOKS_POR_BIT cycles after the pin falling edge.
//    The pulse appears on the following cycle.
//  - Input during LIMPEZA/ESPERA that is not a falling edge is ignored.
//  - No overrun detection: the consumer must accept byteRecebido within one frame time.
// STRUCTURE
//  - uart_defs.vh, shared with uart_tx: state encodings
//    (ESPERA=0, VERIFICA_INICIO=1, RECEBE_BITS=2, RECEBE_FINAL=3, LIMPEZA=4) and default CLOKS_POR_BIT.
//  - Sub-module sincronizador_2ff (1-bit, reset value parameterised, here 1).
//    Reused for other asynchronous inputs such as the DHT11 data line.
//  - FSM, counter and shift register stay in uart_rx.
// TESTING (bench CLOKS_POR_BIT=16, METADE=7, unless noted)
//  1. Good frame 0x55 -> exactly one dadoValido pulse, byteRecebido=0x55, erroDeQuadro stays 0.
//  2. Frames 0xA5 then 0x3C, back-to-back with one stop bit -> two pulses, values 0xA5 then 0x3C.
//  3. 5-cycle low glitch on idle line -> no pulse, recepcaoEmAndamento returns 0, FSM back to ESPERA.
//  4. Frame 0xFF with stop=0, then line held low 40 cycles, then high, then frame 0x81
//     -> erroDeQuadro pulse with byteRecebido still prior value; no spurious arm; then dadoValido with 0x81.
//  5. reset pulsed during data bit 4 of frame 0xF0
//     -> all outputs 0, no pulse for the aborted frame; next frame 0x0F received correctly.
//  6. Loopback against uart_tx at CLOKS_POR_BIT=5209, byte 0xC3 -> byteRecebido=0xC3 with one dadoValido.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver state encodings and default bit period shared with uart_tx
package uart_rx_pkg;
    typedef enum logic [2:0] {
        ESPERA          = 3'd0,
        VERIFICA_INICIO = 3'd1,
        RECEBE_BITS     = 3'd2,
        RECEBE_FINAL    = 3'd3,
        LIMPEZA         = 3'd4
    } estado_t;
    localparam int CLOKS_POR_BIT_PADRAO = 5209;
endpackage

// File: rtl/uart_rx_sincronizador_2ff.sv
// uart_rx_sincronizador_2ff: two-flop synchroniser for one asynchronous input
module uart_rx_sincronizador_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic assincrono,
    output logic sincronizado
);
    logic [1:0] ff_q, ff_d;
    always_comb ff_d = {ff_q[0], assincrono};
    always_ff @(posedge clock) ff_q <= reset ? {2{RESET_VAL}} : ff_d;
    assign sincronizado = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-glitch rejection, centre sampling and framing-error flag
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOKS_POR_BIT = CLOKS_POR_BIT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bitSerialRecebido,
    output logic [7:0] byteRecebido,
    output logic       dadoValido,
    output logic       erroDeQuadro,
    output logic       recepcaoEmAndamento
);
    localparam int CW = $clog2(CLOKS_POR_BIT);
    localparam logic [CW-1:0] METADE = CW'((CLOKS_POR_BIT - 1) / 2);
    localparam logic [CW-1:0] ULTIMO = CW'(CLOKS_POR_BIT - 1);
    estado_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d, byte_q, byte_d;
    logic valid_q, valid_d, err_q, err_d, busy_q, busy_d, prev_q;
    logic linha_sync;
    uart_rx_sincronizador_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clock       (clock),
        .reset       (reset),
        .assincrono  (bitSerialRecebido),
        .sincronizado(linha_sync)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ESPERA: begin
                cnt_d   = '0;
                state_d = (prev_q && !linha_sync) ? VERIFICA_INICIO : ESPERA;
            end
            VERIFICA_INICIO: if (cnt_q == METADE) begin
                cnt_d   = '0;
                busy_d  = !linha_sync;
                state_d = linha_sync ? ESPERA : RECEBE_BITS;
            end
            RECEBE_BITS: if (cnt_q == ULTIMO) begin
                cnt_d          = '0;
                shift_d[idx_q] = linha_sync;
                idx_d          = idx_q + 3'd1;
                state_d        = (idx_q == 3'd7) ? RECEBE_FINAL : RECEBE_BITS;
            end
            RECEBE_FINAL: if (cnt_q == ULTIMO) begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                byte_d  = linha_sync ? shift_q : byte_q;
                valid_d = linha_sync;
                err_d   = !linha_sync;
                state_d = LIMPEZA;
            end
            default: begin
                cnt_d   = '0;
                state_d = ESPERA;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ESPERA;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            prev_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            prev_q  <= linha_sync;
        end
    end
    assign byteRecebido        = byte_q;
    assign dadoValido          = valid_q;
    assign erroDeQuadro        = err_q;
    assign recepcaoEmAndamento = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at a short bit period plus one full-rate loopback frame
module tb_uart_rx;
    localparam int CPB  = 16;
    localparam int CPB2 = 5209;
    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx2 = 1'b1;
    logic [7:0] byte1, byte2;
    logic val1, val2, err1, err2, busy1, busy2;
    int checks = 0, failures = 0;
    int nval1 = 0, nerr1 = 0, both1 = 0, nval2 = 0, nerr2 = 0;
    logic saw_busy = 1'b0;
    logic [7:0] byte_at_err = 8'h00;
    logic [7:0] log1[$];
    always #5 clk = ~clk;
    uart_rx #(.CLOKS_POR_BIT(CPB)) dut (
        .clock(clk), .reset(rst), .bitSerialRecebido(rx), .byteRecebido(byte1),
        .dadoValido(val1), .erroDeQuadro(err1), .recepcaoEmAndamento(busy1)
    );
    uart_rx #(.CLOKS_POR_BIT(CPB2)) dut2 (
        .clock(clk), .reset(rst), .bitSerialRecebido(rx2), .byteRecebido(byte2),
        .dadoValido(val2), .erroDeQuadro(err2), .recepcaoEmAndamento(busy2)
    );
    always @(negedge clk) begin
        if (val1) begin
            nval1++;
            log1.push_back(byte1);
        end
        if (err1) begin
            nerr1++;
            byte_at_err = byte1;
        end
        if (val1 && err1) both1++;
        if (busy1) saw_busy = 1'b1;
        if (val2) nval2++;
        if (err2) nerr2++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask
    task automatic send_frame(input bit sel, input int cpb, input logic [7:0] b, input logic stop, input int abort_at);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(posedge clk);
                #1;
                if (c == 0) begin
                    if (sel) rx2 = f[i];
                    else rx = f[i];
                end
                if (i == abort_at && c == 8) rst = 1'b1;
                if (i == abort_at && c == 10) begin
                    rst = 1'b0;
                    @(negedge clk);
                    check("t5_rst_byte", 32'(byte1), 32'h00);
                    check("t5_rst_valid", 32'(val1), 32'h0);
                    check("t5_rst_err", 32'(err1), 32'h0);
                    check("t5_rst_busy", 32'(busy1), 32'h0);
                end
            end
        end
    endtask
    initial begin
        int v, e;
        idle(4);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_byte", 32'(byte1), 32'h00);
        check("rst_valid", 32'(val1), 32'h0);
        check("rst_err", 32'(err1), 32'h0);
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'h0);
        check("rst_byte2", 32'(byte2), 32'h00);
        idle(10);
        v = nval1; e = nerr1; saw_busy = 1'b0;
        send_frame(1'b0, CPB, 8'h55, 1'b1, -1);
        idle(20);
        check("t1_pulses", 32'(nval1 - v), 32'd1);
        check("t1_byte", 32'(byte1), 32'h55);
        check("t1_err", 32'(nerr1 - e), 32'd0);
        check("t1_busy_seen", 32'(saw_busy), 32'h1);
        check("t1_busy_idle", 32'(busy1), 32'h0);
        v = log1.size();
        send_frame(1'b0, CPB, 8'hA5, 1'b1, -1);
        send_frame(1'b0, CPB, 8'h3C, 1'b1, -1);
        idle(20);
        check("t2_count", 32'(log1.size() - v), 32'd2);
        if (log1.size() >= v + 2) begin
            check("t2_first", 32'(log1[v]), 32'hA5);
            check("t2_second", 32'(log1[v+1]), 32'h3C);
        end
        check("t2_byte", 32'(byte1), 32'h3C);
        v = nval1; e = nerr1; saw_busy = 1'b0;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        idle(30);
        check("t3_no_pulse", 32'(nval1 - v), 32'd0);
        check("t3_no_err", 32'(nerr1 - e), 32'd0);
        check("t3_busy_seen", 32'(saw_busy), 32'h0);
        check("t3_state", 32'(dut.state_q), 32'h0);
        check("t3_byte", 32'(byte1), 32'h3C);
        v = nval1; e = nerr1;
        send_frame(1'b0, CPB, 8'hFF, 1'b0, -1);
        saw_busy = 1'b0;
        idle(40);
        check("t4_low_busy", 32'(saw_busy), 32'h0);
        check("t4_low_state", 32'(dut.state_q), 32'h0);
        @(posedge clk);
        #1 rx = 1'b1;
        idle(20);
        check("t4_err", 32'(nerr1 - e), 32'd1);
        check("t4_err_byte", 32'(byte_at_err), 32'h3C);
        check("t4_no_valid", 32'(nval1 - v), 32'd0);
        send_frame(1'b0, CPB, 8'h81, 1'b1, -1);
        idle(20);
        check("t4_valid", 32'(nval1 - v), 32'd1);
        check("t4_byte", 32'(byte1), 32'h81);
        check("t4_err_once", 32'(nerr1 - e), 32'd1);
        v = nval1; e = nerr1;
        send_frame(1'b0, CPB, 8'hF0, 1'b1, 5);
        idle(20);
        check("t5_no_pulse", 32'(nval1 - v), 32'd0);
        check("t5_no_err", 32'(nerr1 - e), 32'd0);
        check("t5_byte_cleared", 32'(byte1), 32'h00);
        send_frame(1'b0, CPB, 8'h0F, 1'b1, -1);
        idle(20);
        check("t5_next_pulse", 32'(nval1 - v), 32'd1);
        check("t5_next_byte", 32'(byte1), 32'h0F);
        check("never_both", 32'(both1), 32'd0);
        send_frame(1'b1, CPB2, 8'hC3, 1'b1, -1);
        idle(CPB2);
        check("t6_pulses", 32'(nval2), 32'd1);
        check("t6_byte", 32'(byte2), 32'hC3);
        check("t6_err", 32'(nerr2), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
